// File: rtl/jtpopeye_dma.sv
// rtl/jtpopeye_dma.sv - vblank-triggered bus-master DMA from main RAM into the object line buffer
module jtpopeye_dma #(
    parameter logic [9:0]  START = 10'h000,
    parameter logic [10:0] LEN   = 11'd1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       VB,
    input  logic       busak_n,
    output logic       busrq_n,
    output logic       dma_cs,
    output logic [9:0] AD_DMA,
    input  logic [7:0] DD_DMA,
    output logic [9:0] obj_addr,
    output logic [7:0] obj_data,
    output logic       obj_we,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    typedef enum logic [2:0] {IDLE, REQ, XFER, DRAIN, RELEASE} state_t;

    state_t      state_q, state_d;
    logic        vbl_q, busrq_n_q, busrq_n_d, dma_cs_q, dma_cs_d;
    logic [9:0]  ad_q, ad_d;
    logic [10:0] off_q, off_d;
    logic [9:0]  wr_cnt_q, wr_cnt_d;
    logic        pend_q, pend_d;
    logic [9:0]  obj_addr_q, obj_addr_d;
    logic [7:0]  obj_data_q, obj_data_d;
    logic        obj_we_q, obj_we_d, busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;
    logic        vb_edge;

    assign vb_edge = VB & ~vbl_q;

    always_comb begin
        state_d    = state_q;
        busrq_n_d  = busrq_n_q;
        dma_cs_d   = dma_cs_q;
        ad_d       = ad_q;
        off_d      = off_q;
        wr_cnt_d   = wr_cnt_q;
        pend_d     = 1'b0;
        obj_addr_d = obj_addr_q;
        obj_data_d = obj_data_q;
        obj_we_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overrun_d  = overrun_q | (vb_edge & (state_q != IDLE));

        // pend_q: the RAM latched an address last cen, so its byte is on DD_DMA now
        if (pend_q) begin
            obj_we_d   = 1'b1;
            obj_data_d = DD_DMA;
            obj_addr_d = wr_cnt_q;
            wr_cnt_d   = wr_cnt_q + 10'd1;
        end

        case (state_q)
            IDLE: begin
                if (vb_edge) begin
                    state_d   = REQ;
                    busrq_n_d = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            REQ: begin
                if (!busak_n) begin
                    state_d  = XFER;
                    dma_cs_d = 1'b1;
                    ad_d     = START;
                    off_d    = 11'd1;
                    wr_cnt_d = '0;
                end
            end
            XFER: begin
                pend_d = 1'b1;
                // off_q counts addresses already presented; LEN of them ends the burst
                if (off_q == LEN) begin
                    state_d = DRAIN;
                end else begin
                    ad_d  = ad_q + 10'd1;
                    off_d = off_q + 11'd1;
                end
            end
            DRAIN: begin
                dma_cs_d  = 1'b0;
                busrq_n_d = 1'b1;
                state_d   = RELEASE;
            end
            RELEASE: begin
                if (busak_n) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vbl_q      <= 1'b0;
            busrq_n_q  <= 1'b1;
            dma_cs_q   <= 1'b0;
            ad_q       <= START;
            off_q      <= '0;
            wr_cnt_q   <= '0;
            pend_q     <= 1'b0;
            obj_addr_q <= '0;
            obj_data_q <= '0;
            obj_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else if (cen) begin
            state_q    <= state_d;
            vbl_q      <= VB;
            busrq_n_q  <= busrq_n_d;
            dma_cs_q   <= dma_cs_d;
            ad_q       <= ad_d;
            off_q      <= off_d;
            wr_cnt_q   <= wr_cnt_d;
            pend_q     <= pend_d;
            obj_addr_q <= obj_addr_d;
            obj_data_q <= obj_data_d;
            obj_we_q   <= obj_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    assign busrq_n  = busrq_n_q;
    assign dma_cs   = dma_cs_q;
    assign AD_DMA   = ad_q;
    assign obj_addr = obj_addr_q;
    assign obj_data = obj_data_q;
    assign obj_we   = obj_we_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_jtpopeye_dma.sv
// tb/tb_jtpopeye_dma.sv - randomized self-checking bench for jtpopeye_dma with a timestamp-level reference model
module tb_jtpopeye_dma;
    localparam logic [9:0]  S  = 10'h380;
    localparam logic [10:0] L  = 11'd128;
    localparam int          SI = 'h380;
    localparam int          LI = 128;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic       VB = 1'b0;
    logic       busak_n = 1'b1;
    logic       busrq_n, dma_cs, obj_we, busy, done, overrun;
    logic [9:0] AD_DMA, obj_addr;
    logic [7:0] DD_DMA, obj_data;

    logic [7:0] ram [1024];
    logic [7:0] seq_ref [LI];
    logic [7:0] seq_cur [LI];

    int errors = 0, checks = 0;
    int n = 0, g = -1, wcnt = 0, dones = 0;
    bit mbusy = 1'b0, vbl = 1'b0, movr = 1'b0;
    int gdelay = 3, rdelay = 2, gcnt = 0, rcnt = 0;
    bit glitch = 1'b0, rec_ref = 1'b0, cmp_ref = 1'b0, done_seen = 1'b0;
    int n_vb = -1, n_rq = -1, n_cs = -1, n_we = -1;
    logic [33:0] prev;

    always #5 clk = ~clk;

    // main RAM: registered read, advances on cen like the real board
    always @(posedge clk) if (cen) DD_DMA <= ram[AD_DMA];

    jtpopeye_dma #(.START(S), .LEN(L)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .VB(VB), .busak_n(busak_n),
        .busrq_n(busrq_n), .dma_cs(dma_cs), .AD_DMA(AD_DMA), .DD_DMA(DD_DMA),
        .obj_addr(obj_addr), .obj_data(obj_data), .obj_we(obj_we),
        .busy(busy), .done(done), .overrun(overrun)
    );

    function automatic logic [33:0] outs();
        return {busrq_n, dma_cs, AD_DMA, obj_addr, obj_data, obj_we, busy, done, overrun};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        g = -1; mbusy = 1'b0; vbl = 1'b0; movr = 1'b0; wcnt = 0;
    endtask

    function automatic logic cen_for(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 4) == 0;
            default: return $urandom_range(0, 1) == 1;
        endcase
    endfunction

    task automatic cyc(input logic c);
        bit edge_s, e_done, e_rq, e_cs, e_we;
        int a;
        @(negedge clk);
        cen = c;
        if (c && rst_n) begin
            if (!busrq_n && busak_n) begin
                if (gcnt >= gdelay) begin busak_n = 1'b0; gcnt = 0; end else gcnt++;
            end else if (busrq_n && !busak_n) begin
                if (rcnt >= rdelay) begin busak_n = 1'b1; rcnt = 0; end else rcnt++;
            end else if (glitch && dma_cs && $urandom_range(0, 7) == 0) begin
                busak_n = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            prev = outs();
            return;
        end
        if (c) begin
            n++;
            edge_s = VB && !vbl;
            vbl = VB;
            e_done = 1'b0;
            if (mbusy) begin
                if (edge_s) movr = 1'b1;
                if (g < 0) begin
                    if (!busak_n) g = n;
                end else if (n > g + LI + 1 && busak_n) begin
                    mbusy = 1'b0;
                    e_done = 1'b1;
                end
            end else if (edge_s) begin
                mbusy = 1'b1;
                g = -1;
                if (n_vb < 0) n_vb = n;
            end
            e_rq = !(mbusy && (g < 0 || n < g + LI + 1));
            e_cs = mbusy && g >= 0 && n <= g + LI;
            e_we = mbusy && g >= 0 && n >= g + 2 && n <= g + LI + 1;
            chk("busrq_n", busrq_n, e_rq);
            chk("dma_cs", dma_cs, e_cs);
            chk("obj_we", obj_we, e_we);
            chk("busy", busy, mbusy);
            chk("done", done, e_done);
            chk("overrun", overrun, movr);
            if (e_cs) chk("AD_DMA", AD_DMA, SI + ((n - g < LI - 1) ? n - g : LI - 1));
            if (e_we) begin
                a = n - g - 2;
                chk("obj_addr", obj_addr, a);
                chk("obj_data", obj_data, ram[SI + a]);
            end
            if (!busrq_n && n_rq < 0) n_rq = n;
            if (dma_cs && n_cs < 0) n_cs = n;
            if (obj_we && n_we < 0) n_we = n;
            if (obj_we) begin
                if (wcnt < LI) seq_cur[wcnt] = obj_data;
                wcnt++;
            end
            if (done) begin
                chk("writes_per_xfer", wcnt, LI);
                if (rec_ref) seq_ref = seq_cur;
                if (cmp_ref) begin
                    int m;
                    m = 0;
                    for (int k = 0; k < LI; k++) if (seq_cur[k] !== seq_ref[k]) m++;
                    chk("seq_vs_full_cen_run", m, 0);
                end
                wcnt = 0;
                dones++;
                done_seen = 1'b1;
            end
        end else begin
            chk("hold_when_cen0", outs(), prev);
        end
        prev = outs();
    endtask

    task automatic run(input int mode, input int budget, input bit ovr, input bit rnd_vb, input int probe);
        VB = 1'b0;
        cyc(1'b1);
        cyc(1'b1);
        n_vb = -1; n_rq = -1; n_cs = -1; n_we = -1;
        done_seen = 1'b0;
        VB = 1'b1;
        for (int k = 0; k < budget && !done_seen; k++) begin
            if (k == 40) VB = 1'b0;
            if (ovr && k == 60) VB = 1'b1;
            if (ovr && k == 70) VB = 1'b0;
            if (rnd_vb && k > 40 && $urandom_range(0, 15) == 0) VB = ~VB;
            if (k == probe) begin
                chk("late_busrq_low", busrq_n, 1'b0);
                chk("late_no_dma_cs", dma_cs, 1'b0);
                chk("late_no_we", obj_we, 1'b0);
            end
            cyc(cen_for(mode, k));
        end
        chk("done_within_budget", done_seen, 1'b1);
        VB = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
        #12;
        chk("rst_busrq_n", busrq_n, 1'b1);
        chk("rst_dma_cs", dma_cs, 1'b0);
        chk("rst_AD_DMA", AD_DMA, S);
        chk("rst_obj_addr", obj_addr, 10'd0);
        chk("rst_obj_data", obj_data, 8'd0);
        chk("rst_obj_we", obj_we, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        prev = outs();

        rec_ref = 1'b1;
        run(0, 1000, 1'b0, 1'b0, -1);
        rec_ref = 1'b0;
        chk("rq_on_vb_cen", n_rq - n_vb, 0);
        chk("grant_to_first_we", n_we - n_cs, 2);
        chk("busrq_high_after", busrq_n, 1'b1);
        chk("dones_basic", dones, 1);

        gdelay = 500;
        run(0, 2000, 1'b0, 1'b0, 300);
        gdelay = 3;
        chk("late_grant_to_first_we", n_we - n_cs, 2);

        run(0, 1000, 1'b1, 1'b0, -1);
        chk("overrun_set", overrun, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b1);
        chk("no_second_request", busrq_n, 1'b1);
        chk("dones_after_overrun", dones, 3);

        VB = 1'b0;
        cyc(1'b1);
        cyc(1'b1);
        VB = 1'b1;
        for (int k = 0; k < 1000 && wcnt < 100; k++) begin
            if (k == 40) VB = 1'b0;
            cyc(1'b1);
        end
        chk("reached_write_100", wcnt, 100);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busrq_n", busrq_n, 1'b1);
        chk("midrst_dma_cs", dma_cs, 1'b0);
        chk("midrst_obj_we", obj_we, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        VB = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        prev = outs();
        for (int i = 0; i < 5; i++) cyc(1'b1);
        chk("dones_after_midrst", dones, 3);

        run(0, 1000, 1'b0, 1'b0, -1);
        chk("dones_clean_after_rst", dones, 4);

        cmp_ref = 1'b1;
        run(1, 3000, 1'b0, 1'b0, -1);
        cmp_ref = 1'b0;
        chk("dones_gated", dones, 5);

        glitch = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
            gdelay = $urandom_range(0, 20);
            rdelay = $urandom_range(0, 10);
            run(2, 3000, 1'b0, 1'b1, -1);
        end
        glitch = 1'b0;
        chk("dones_total", dones, 11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jtpopeye_dma.md
Name: jtpopeye_dma

Overview:
- Bus-master DMA engine on the video side: the initiator end of the main board's busrq_n/busak_n/dma_cs/AD_DMA/DD_DMA port.
- On each vertical blank it requests the Z80 bus and waits for grant.
- Then it streams a block of main RAM (upper 1 KB window, 0x8400–0x87FF) into the object line buffer through a simple write port.
- After the block it releases the bus.

Parameters:
- START, 10'h000: first AD_DMA offset within the 1 KB window.
- LEN, 11'd1024: bytes per transfer, 1..1024. START+LEN must not exceed 1024; no wrap is supported.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- cen  in  1  clock enable, same as main cpu_cen; all state advances only when cen=1
- VB  in  1  vertical blank; its rising edge triggers a transfer
- busak_n  in  1  bus acknowledge from CPU, active low
- busrq_n  out  1  bus request to CPU, active low
- dma_cs  out  1  selects DMA addressing on main RAM
- AD_DMA  out  10  RAM offset (RAM address = {1'b1, AD_DMA})
- DD_DMA  in  8  RAM read data; registered in RAM, valid one cen after its address
- obj_addr  out  10  object buffer write address (0..LEN-1)
- obj_data  out  8  object buffer write data
- obj_we  out  1  object buffer write strobe, one cen wide
- busy  out  1  high from request until release completes
- done  out  1  one-cen pulse when a transfer ends
- overrun  out  1  sticky; set if a VB edge arrives while busy; cleared by reset only

Behaviour:
- Reset values (asynchronous, immediate): busrq_n=1, dma_cs=0, AD_DMA=START, obj_addr=0, obj_data=0, obj_we=0, busy=0, done=0, overrun=0, state=IDLE.
- VB is sampled on cen into VBl; edge = VB & ~VBl.
- IDLE: on edge, go to REQ and set busrq_n=0, busy=1 (both registered, same cen).
- REQ: hold busrq_n=0. On the first cen with busak_n=0, go to XFER, set dma_cs=1, AD_DMA=START. There is no timeout; the block waits indefinitely.
- XFER, per cen:
  - AD_DMA increments by 1.
  - On the cen after each address is presented, capture obj_data<=DD_DMA and pulse obj_we=1, with obj_addr = that address - START.
  - When AD_DMA = START+LEN-1 has been presented, go to DRAIN. dma_cs stays 1.
- DRAIN: one cen. Capture the final byte (obj_we=1, obj_addr=LEN-1). Then dma_cs=0, busrq_n=1, go to RELEASE.
- RELEASE: wait for busak_n=1. On that cen: busy=0, done=1 for one cen, go to IDLE.
- Latency:
  - VB edge to busrq_n low: 1 cen.
  - Grant to first obj_we: 2 cens.
  - Total obj_we pulses = LEN exactly, addresses 0..LEN-1 in order, no gaps.
- busak_n deasserting during XFER/DRAIN (protocol violation): ignored; the transfer continues to completion.
- VB edge while busy: ignored for transfer purposes; sets overrun.
- VB falling mid-transfer: no effect.
- LEN=1: XFER lasts one cen, then DRAIN; one obj_we, at obj_addr 0.
- cen=0 cycles: all outputs hold. obj_we is sampled by the consumer on cen only.
- Reset mid-transfer: bus released immediately (busrq_n=1, dma_cs=0), no further writes, no done pulse.
- Widths: the internal count is 11 bits to hold LEN=1024. AD_DMA never exceeds START+LEN-1.

Test Plan:
- Basic: START=0, LEN=1024, RAM preset to data=addr[7:0]; VB rise, busak_n granted 3 cens after busrq_n falls -> exactly 1024 obj_we, obj_data[n]=n[7:0], done pulses once, busrq_n high afterwards.
- Offset window: START=10'h200, LEN=16 -> AD_DMA runs 0x200..0x20F, obj_addr runs 0..15, first obj_we 2 cens after grant.
- Late grant: hold busak_n=1 for 500 cens -> busrq_n stays low, dma_cs=0, no obj_we until grant, then normal transfer.
- Overrun: second VB edge during XFER -> overrun=1, still only LEN writes, no second busrq_n cycle until a later VB edge after IDLE.
- Reset mid-transfer: assert rst_n=0 at write 100 -> busrq_n=1, dma_cs=0 without waiting for clk, no done pulse; next VB performs a full clean transfer.
- cen gating: cen toggling 1-in-4 -> identical obj_addr/obj_data sequence to the cen=1 run, obj_we asserted only alongside cen.
